// File: rtl/de0_cv_mode_switch_ctrl.sv
// Debounces the PIO mode code and hands the datapath over to the new mode:
// quiesce the active datapath, commit the new mode, then strobe switch_pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no switch in progress; watching sel_q against active_mode
// SETTLE | candidate latched; waiting for SETTLE_CYC stable cycles
// DRAIN  | quiesce_req high; waiting for idle_in or the drain timeout
// COMMIT | active_mode just updated; single cycle, back to IDLE
module de0_cv_mode_switch_ctrl #(
    parameter int MODE_W     = 3,
    parameter int NUM_MODES  = 5,
    parameter int RESET_MODE = 0,
    parameter int SETTLE_CYC = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              idle_in,
    output logic              quiesce_req,
    output logic [MODE_W-1:0] active_mode,
    output logic              switch_pulse,
    output logic              busy,
    output logic              invalid_req,
    output logic              timeout_err
);

    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT) ? SETTLE_CYC : TIMEOUT;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [MODE_W-1:0] RESET_CODE   = MODE_W'(RESET_MODE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DRAIN,
        S_COMMIT
    } state_t;

    state_t            state, state_nxt;
    logic [MODE_W-1:0] sel_q;
    logic [MODE_W-1:0] cand, cand_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [MODE_W-1:0] active_nxt;
    logic              terr_nxt;

    function automatic logic code_valid(input logic [MODE_W-1:0] code);
        return 32'(code) < NUM_MODES;
    endfunction

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        terr_nxt  = timeout_err;

        case (state)
            S_IDLE: begin
                if (code_valid(sel_q) && (sel_q != active_mode)) begin
                    state_nxt = S_SETTLE;
                    cand_nxt  = sel_q;
                    cnt_nxt   = '0;
                end
            end
            S_SETTLE: begin
                // A change while settling is a glitch; IDLE re-evaluates the new value.
                if (sel_q != cand) begin
                    state_nxt = S_IDLE;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (idle_in) begin
                    state_nxt = S_COMMIT;
                    terr_nxt  = 1'b0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = S_COMMIT;
                    terr_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        active_nxt = (state_nxt == S_COMMIT) ? cand : active_mode;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            sel_q        <= '0;
            cand         <= '0;
            cnt          <= '0;
            active_mode  <= RESET_CODE;
            quiesce_req  <= 1'b0;
            switch_pulse <= 1'b0;
            busy         <= 1'b0;
            invalid_req  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            sel_q        <= mode_sel;
            cand         <= cand_nxt;
            cnt          <= cnt_nxt;
            active_mode  <= active_nxt;
            quiesce_req  <= (state_nxt == S_DRAIN);
            switch_pulse <= (state_nxt == S_COMMIT);
            busy         <= (state_nxt != S_IDLE);
            invalid_req  <= !code_valid(mode_sel);
            timeout_err  <= terr_nxt;
        end
    end

endmodule

// File: tb/tb_de0_cv_mode_switch_ctrl.sv
// Bench for de0_cv_mode_switch_ctrl: directed scenarios then randomized
// mode/idle traffic, checked every cycle against an age-counter reference model.
module tb_de0_cv_mode_switch_ctrl;

    localparam int MODE_W     = 3;
    localparam int NUM_MODES  = 5;
    localparam int RESET_MODE = 0;
    localparam int SETTLE_CYC = 2;
    localparam int TIMEOUT    = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic [MODE_W-1:0] mode_sel;
    logic              idle_in;
    logic              quiesce_req;
    logic [MODE_W-1:0] active_mode;
    logic              switch_pulse;
    logic              busy;
    logic              invalid_req;
    logic              timeout_err;

    int tests = 0;
    int fails = 0;
    string ph = "init";

    // Reference model: m_age counts edges since a candidate was accepted
    // (0 = none); ages beyond SETTLE_CYC are drain cycles.
    logic [MODE_W-1:0] m_sel_q, m_cand, m_active;
    int                m_age;
    bit                m_committing;
    bit                m_quiesce, m_pulse, m_busy, m_invalid, m_terr;

    de0_cv_mode_switch_ctrl #(
        .MODE_W    (MODE_W),
        .NUM_MODES (NUM_MODES),
        .RESET_MODE(RESET_MODE),
        .SETTLE_CYC(SETTLE_CYC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_sel    (mode_sel),
        .idle_in     (idle_in),
        .quiesce_req (quiesce_req),
        .active_mode (active_mode),
        .switch_pulse(switch_pulse),
        .busy        (busy),
        .invalid_req (invalid_req),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_sel_q      = '0;
        m_cand       = '0;
        m_active     = MODE_W'(RESET_MODE);
        m_age        = 0;
        m_committing = 1'b0;
        m_quiesce    = 1'b0;
        m_pulse      = 1'b0;
        m_busy       = 1'b0;
        m_invalid    = 1'b0;
        m_terr       = 1'b0;
    endtask

    task automatic model_commit(input bit forced);
        m_active     = m_cand;
        m_pulse      = 1'b1;
        m_committing = 1'b1;
        m_terr       = forced;
        m_age        = 0;
    endtask

    task automatic model_edge(input logic [MODE_W-1:0] sel, input logic idle);
        m_pulse = 1'b0;
        if (m_committing) begin
            m_committing = 1'b0;
        end else if (m_age == 0) begin
            if ((int'(m_sel_q) < NUM_MODES) && (m_sel_q != m_active)) begin
                m_cand = m_sel_q;
                m_age  = 1;
            end
        end else if (m_age <= SETTLE_CYC) begin
            if (m_sel_q != m_cand) m_age = 0;
            else                   m_age++;
        end else begin
            if (idle)                              model_commit(1'b0);
            else if (m_age - SETTLE_CYC == TIMEOUT) model_commit(1'b1);
            else                                   m_age++;
        end
        m_quiesce = (m_age > SETTLE_CYC);
        m_busy    = (m_age != 0) || m_committing;
        m_sel_q   = sel;
        m_invalid = (int'(sel) >= NUM_MODES);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", ph, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("quiesce_req",  32'(quiesce_req),  32'(m_quiesce));
        check("active_mode",  32'(active_mode),  32'(m_active));
        check("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
        check("busy",         32'(busy),         32'(m_busy));
        check("invalid_req",  32'(invalid_req),  32'(m_invalid));
        check("timeout_err",  32'(timeout_err),  32'(m_terr));
    endtask

    task automatic step(input logic [MODE_W-1:0] sel, input logic idle);
        mode_sel = sel;
        idle_in  = idle;
        @(posedge clk);
        model_edge(sel, idle);
        #1;
        check_all();
    endtask

    initial begin
        reset    = 1'b1;
        mode_sel = '0;
        idle_in  = 1'b1;
        model_reset();
        #12;
        ph = "reset";
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Normal switch 0->3: commit visible at edge 5, busy low at edge 6.
        ph = "normal";
        repeat (3) step(3'd3, 1'b1);
        step(3'd3, 1'b1);
        check("q_edge4", 32'(quiesce_req), 32'd1);
        step(3'd3, 1'b1);
        check("act_edge5", 32'(active_mode), 32'd3);
        check("pulse_edge5", 32'(switch_pulse), 32'd1);
        step(3'd3, 1'b1);
        check("busy_edge6", 32'(busy), 32'd0);
        repeat (2) step(3'd3, 1'b1);

        ph = "glitch";
        step(3'd2, 1'b1);
        repeat (6) step(3'd3, 1'b1);
        check("glitch_act", 32'(active_mode), 32'd3);

        // Request 1 with idle_in low for 10 drain cycles.
        ph = "drain_wait";
        repeat (14) step(3'd1, 1'b0);
        step(3'd1, 1'b1);
        check("drain_act", 32'(active_mode), 32'd1);
        check("drain_terr", 32'(timeout_err), 32'd0);
        repeat (2) step(3'd1, 1'b1);

        ph = "timeout";
        repeat (4 + TIMEOUT) step(3'd4, 1'b0);
        check("to_act", 32'(active_mode), 32'd4);
        check("to_terr", 32'(timeout_err), 32'd1);
        repeat (4) step(3'd4, 1'b1);
        ph = "timeout_clear";
        repeat (7) step(3'd0, 1'b1);
        check("clr_terr", 32'(timeout_err), 32'd0);

        ph = "invalid";
        repeat (3) step(3'd6, 1'b1);
        check("inv_level", 32'(invalid_req), 32'd1);
        repeat (7) step(3'd1, 1'b1);

        ph = "late_change";
        repeat (4) step(3'd3, 1'b0);
        repeat (2) step(3'd4, 1'b0);
        step(3'd4, 1'b1);
        check("late_first", 32'(active_mode), 32'd3);
        repeat (8) step(3'd4, 1'b1);
        check("late_second", 32'(active_mode), 32'd4);

        ph = "reset_mid";
        repeat (5) step(3'd2, 1'b0);
        #2;
        reset    = 1'b1;
        mode_sel = '0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        repeat (6) step(3'd0, 1'b1);

        ph = "random";
        for (int blk = 0; blk < 300; blk++) begin
            logic [MODE_W-1:0] sel;
            int len;
            sel = MODE_W'($urandom_range(0, 7));
            len = $urandom_range(1, 20);
            for (int c = 0; c < len; c++) begin
                step(sel, ($urandom_range(0, 3) != 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
